// File: rtl/ddc_channel_scheduler_if.sv
// ddc_channel_scheduler_if: I2S capture, CIC handshake
// and lock/status signals of the stereo scheduler.
interface ddc_channel_scheduler_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] left_data;
  logic                  left_data_valid;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  right_data_valid;
  logic [DATA_WIDTH-1:0] cic_data;
  logic                  cic_chan;
  logic                  cic_valid;
  logic                  cic_ready;
  logic                  locked;
  logic [1:0]            overrun;
  logic                  lock_lost;
  logic                  clear_status;

  modport master (
    output left_data, left_data_valid,
    output right_data, right_data_valid,
    output cic_ready, clear_status,
    input  cic_data, cic_chan, cic_valid,
    input  locked, overrun, lock_lost
  );

  modport slave (
    input  left_data, left_data_valid,
    input  right_data, right_data_valid,
    input  cic_ready, clear_status,
    output cic_data, cic_chan, cic_valid,
    output locked, overrun, lock_lost
  );
endinterface

// File: rtl/ddc_channel_scheduler.sv
// ddc_channel_scheduler: round-robin L/R issue to shared CIC
// with lrclk lock tracking. DDC_SCHED_MUTE_EN mutes data in SEARCH.
module ddc_channel_scheduler #(
  parameter int DATA_WIDTH    = 16,
  parameter int LOCK_FRAMES   = 4,
  parameter int FRAME_TIMEOUT = 96
) (
  input logic bclk,
  input logic rst,
  ddc_channel_scheduler_if.slave bus
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(FRAME_TIMEOUT);
  localparam logic [3:0] LOCKN = 4'(LOCK_FRAMES);

  typedef enum logic {SEARCH, RUN} state_t;

  logic [DATA_WIDTH-1:0] hold_l_q, hold_r_q;
  logic                  pend_l_q, pend_r_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, chan_q, last_q;
  logic [TW-1:0]         timer_q;
  logic                  seen_r_q;
  logic [3:0]            cnt_q;
  state_t                state_q;
  logic                  locked_q, lost_q;
  logic [1:0]            ovr_q, ovr_set;

  logic out_free, load, sel_r;
  logic drain_l, drain_r;
  logic good, bad, tmo;
  logic lv, rv;

  assign lv       = bus.left_data_valid;
  assign rv       = bus.right_data_valid;
  assign out_free = !valid_q || bus.cic_ready;
  assign load     = out_free && (pend_l_q || pend_r_q);
  assign sel_r    = pend_r_q && (!pend_l_q || !last_q);
  assign drain_l  = load && !sel_r;
  assign drain_r  = load && sel_r;

  assign ovr_set[0] = lv && pend_l_q && !drain_l;
  assign ovr_set[1] = rv && pend_r_q && !drain_r;

  assign tmo  = !lv && (timer_q == TMAX - 1'b1);
  assign good = lv && seen_r_q && (timer_q < TMAX);
  assign bad  = (lv && !good) || tmo;

  // Output data source; silence while unlocked when muting.
  always_comb begin
    data_d = sel_r ? hold_r_q : hold_l_q;
`ifdef DDC_SCHED_MUTE_EN
    if (state_q != RUN) data_d = '0;
`else
`endif
  end

  // Per-channel holding registers and pending flags.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
    end else begin
      if (lv) begin
        hold_l_q <= bus.left_data;
        pend_l_q <= 1'b1;
      end else if (drain_l) begin
        pend_l_q <= 1'b0;
      end
      if (rv) begin
        hold_r_q <= bus.right_data;
        pend_r_q <= 1'b1;
      end else if (drain_r) begin
        pend_r_q <= 1'b0;
      end
    end
  end

  // Output register; frozen while stalled.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= 1'b0;
      last_q  <= 1'b1;
    end else if (out_free) begin
      valid_q <= load;
      if (load) begin
        data_q <= data_d;
        chan_q <= sel_r;
        last_q <= sel_r;
      end
    end
  end

  // Frame timer and right-seen tracking.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      seen_r_q <= 1'b0;
    end else begin
      if (lv) timer_q <= '0;
      else if (timer_q != TMAX) timer_q <= timer_q + 1'b1;
      if (lv) seen_r_q <= rv;
      else if (rv) seen_r_q <= 1'b1;
    end
  end

  // Lock FSM with registered locked output.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (bad) begin
            cnt_q <= '0;
          end else if (good) begin
            if (cnt_q + 4'd1 == LOCKN) begin
              cnt_q    <= '0;
              state_q  <= RUN;
              locked_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        RUN: begin
          if (bad) begin
            cnt_q    <= '0;
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  // Sticky status; a set on the clearing edge wins.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      ovr_q  <= 2'b00;
      lost_q <= 1'b0;
    end else begin
      ovr_q  <= (bus.clear_status ? 2'b00 : ovr_q) | ovr_set;
      lost_q <= (bus.clear_status ? 1'b0 : lost_q)
              | (state_q == RUN && bad);
    end
  end

  assign bus.cic_valid = valid_q;
  assign bus.cic_data  = data_q;
  assign bus.cic_chan  = chan_q;
  assign bus.locked    = locked_q;
  assign bus.overrun   = ovr_q;
  assign bus.lock_lost = lost_q;

endmodule

// File: tb/tb_ddc_channel_scheduler.sv
// tb_ddc_channel_scheduler: scoreboard bench for the
// stereo CIC scheduler (directed frames, lock, stall, reset).
module tb_ddc_channel_scheduler;

`ifdef DDC_SCHED_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic bclk = 1'b0;
  logic rst  = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [16:0] exp_q[$];

  ddc_channel_scheduler_if #(.DATA_WIDTH(16)) bus();

  ddc_channel_scheduler #(
    .DATA_WIDTH(16),
    .LOCK_FRAMES(4),
    .FRAME_TIMEOUT(96)
  ) dut (
    .bclk(bclk),
    .rst(rst),
    .bus(bus)
  );

  always #5 bclk = ~bclk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] mv(input logic [15:0] d,
                                     input bit run);
    return (MUTE && !run) ? 16'h0000 : d;
  endfunction

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  // Monitor: pops on every accept, checks stall stability.
  logic [16:0] prev;
  bit stall = 0;
  always @(negedge bclk) begin
    if (rst) begin
      stall = 0;
    end else begin
      if (stall) begin
        n_cmp++;
        if ({bus.cic_valid, bus.cic_chan, bus.cic_data}
            !== {1'b1, prev}) begin
          n_err++;
          $display("FAIL stall_hold: got %b/%h expected 1/%h",
                   bus.cic_valid,
                   {bus.cic_chan, bus.cic_data}, prev);
        end
      end
      if (bus.cic_valid && bus.cic_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got %h expected none",
                   {bus.cic_chan, bus.cic_data});
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({bus.cic_chan, bus.cic_data} !== e) begin
            n_err++;
            $display("FAIL out_word: got %h expected %h",
                     {bus.cic_chan, bus.cic_data}, e);
          end
        end
      end
      stall = bus.cic_valid && !bus.cic_ready;
      prev  = {bus.cic_chan, bus.cic_data};
    end
  end

  // One 64-cycle frame: L at cycle 0, R at cycle 32.
  task automatic frame(input logic [15:0] l, r,
                       input bit do_l, do_r, push, run,
                       input int exp_lock, input bit lat);
    for (int i = 0; i < 64; i++) begin
      bus.left_data        = l;
      bus.right_data       = r;
      bus.left_data_valid  = do_l && (i == 0);
      bus.right_data_valid = do_r && (i == 32);
      if (push && do_l && i == 0)
        exp_q.push_back({1'b0, mv(l, run)});
      if (push && do_r && i == 32)
        exp_q.push_back({1'b1, mv(r, run)});
      tick();
      bus.left_data_valid  = 1'b0;
      bus.right_data_valid = 1'b0;
      if (i == 0 && exp_lock >= 0)
        chk("locked_at_left", 32'(bus.locked), 32'(exp_lock));
      if (lat && i == 1)
        chk("lat_left", {bus.cic_valid, bus.cic_chan}, 2'b10);
      if (lat && i == 33)
        chk("lat_right", {bus.cic_valid, bus.cic_chan}, 2'b11);
    end
  endtask

  // Simultaneous L/R pulse at cycle 0 of a 64-cycle frame.
  task automatic pair(input logic [15:0] l, r);
    for (int i = 0; i < 64; i++) begin
      bus.left_data        = l;
      bus.right_data       = r;
      bus.left_data_valid  = (i == 0);
      bus.right_data_valid = (i == 0);
      if (i == 0) begin
        exp_q.push_back({1'b0, l});
        exp_q.push_back({1'b1, r});
      end
      tick();
      bus.left_data_valid  = 1'b0;
      bus.right_data_valid = 1'b0;
      if (i == 1) chk("pair_first", 32'(bus.cic_chan), 0);
      if (i == 2) chk("pair_second", 32'(bus.cic_chan), 1);
    end
  endtask

  task automatic clr();
    bus.clear_status = 1'b1;
    tick();
    bus.clear_status = 1'b0;
  endtask

  initial begin
    bus.left_data        = '0;
    bus.right_data       = '0;
    bus.left_data_valid  = 1'b0;
    bus.right_data_valid = 1'b0;
    bus.cic_ready        = 1'b1;
    bus.clear_status     = 1'b0;
    tick();
    tick();
    chk("rst_outputs",
        {bus.cic_valid, bus.cic_chan, bus.cic_data,
         bus.locked, bus.overrun, bus.lock_lost}, '0);
    rst = 1'b0;
    tick();

    // Lock acquisition with nominal frames.
    for (int f = 0; f < 6; f++)
      frame(16'h1234, 16'h5678, 1, 1, 1, f >= 4,
            (f >= 4) ? 1 : 0, 1);

    // Simultaneous pairs: left first each time.
    pair(16'hA001, 16'hB001);
    pair(16'hA002, 16'hB002);
    chk("t2_status",
        {bus.locked, bus.overrun, bus.lock_lost}, 4'b1000);

    // Stall 200 cycles across 3 frames.
    bus.cic_ready = 1'b0;
    frame(16'h0A01, 16'h0B01, 1, 1, 0, 1, 1, 0);
    frame(16'h0A02, 16'h0B02, 1, 1, 0, 1, 1, 0);
    frame(16'h0A03, 16'h0B03, 1, 1, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("stall_word",
        {bus.cic_valid, bus.cic_chan, bus.cic_data},
        {1'b1, 1'b0, 16'h0A01});
    chk("overrun_both", 32'(bus.overrun), 2'b11);
    exp_q.push_back({1'b0, 16'h0A01});
    exp_q.push_back({1'b1, 16'h0B03});
    exp_q.push_back({1'b0, 16'h0A03});
    bus.cic_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    clr();
    chk("overrun_clr", 32'(bus.overrun), 0);

    // lrclk stops: lock drops at timeout.
    bus.left_data       = 16'h1111;
    bus.left_data_valid = 1'b1;
    exp_q.push_back({1'b0, 16'h1111});
    for (int i = 0; i <= 96; i++) begin
      tick();
      bus.left_data_valid = 1'b0;
      if (i == 95) chk("lock_t95", 32'(bus.locked), 1);
      if (i == 96) begin
        chk("lock_t96", 32'(bus.locked), 0);
        chk("lost_tmo", 32'(bus.lock_lost), 1);
      end
    end

    // Relock after timeout.
    for (int f = 0; f < 5; f++)
      frame(16'h2468, 16'h1357, 1, 1, 1, f >= 4,
            (f >= 4) ? 1 : 0, 0);
    clr();
    chk("lost_clr", 32'(bus.lock_lost), 0);

    // Dropped right pulse.
    frame(16'hAAAA, 16'h0000, 1, 0, 1, 1, 1, 0);
    frame(16'hBBBB, 16'h0000, 1, 0, 1, 0, 0, 0);
    chk("drop_lost", {bus.locked, bus.lock_lost}, 2'b01);

    // Capture during drain, then right wins after left.
    bus.left_data       = 16'h3333;
    bus.left_data_valid = 1'b1;
    exp_q.push_back({1'b0, mv(16'h3333, 0)});
    tick();
    bus.left_data        = 16'h4444;
    bus.right_data       = 16'h5555;
    bus.right_data_valid = 1'b1;
    exp_q.push_back({1'b1, mv(16'h5555, 0)});
    exp_q.push_back({1'b0, mv(16'h4444, 0)});
    tick();
    bus.left_data_valid  = 1'b0;
    bus.right_data_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("drain_no_ovr", 32'(bus.overrun), 0);

    // Reset mid-handshake.
    bus.cic_ready        = 1'b0;
    bus.left_data        = 16'hCCCC;
    bus.right_data       = 16'hDDDD;
    bus.left_data_valid  = 1'b1;
    bus.right_data_valid = 1'b1;
    tick();
    bus.left_data_valid  = 1'b0;
    bus.right_data_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(bus.cic_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs",
        {bus.cic_valid, bus.cic_chan, bus.cic_data,
         bus.locked, bus.overrun, bus.lock_lost}, '0);
    tick();
    rst = 1'b0;
    bus.cic_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("no_stale", 32'(bus.cic_valid), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddc_channel_scheduler.md
# ddc_channel_scheduler

Stereo scheduler between the I2S receiver and a single shared CIC3 interpolator in the DDC pipeline. It captures left/right words into per-channel holding registers and issues them one at a time over a valid/ready handshake, tagged with a channel bit, alternating round-robin. It also tracks lrclk frame lock and forces silence into the interpolator until lock is established.

## Interface
- DATA_WIDTH, 16, sample width of I2S words and scheduler output
- LOCK_FRAMES, 4, consecutive good frames needed to enter RUN (1..15)
- FRAME_TIMEOUT, 96, max bclk cycles between left-valid pulses before a frame is declared lost (nominal frame is 64)

- bclk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- left_data  in  DATA_WIDTH  left word from I2S receiver
- left_data_valid  in  1  one-cycle pulse, left_data valid
- right_data  in  DATA_WIDTH  right word
- right_data_valid  in  1  one-cycle pulse, right_data valid
- cic_data  out  DATA_WIDTH  sample to shared CIC
- cic_chan  out  1  0 = left, 1 = right
- cic_valid  out  1  cic_data/cic_chan valid; held until accepted
- cic_ready  in  1  CIC accepts when cic_valid & cic_ready
- locked  out  1  high in RUN state
- overrun  out  2  sticky per-channel overwrite flags, bit0 left, bit1 right
- lock_lost  out  1  sticky, set on RUN -> SEARCH transition
- clear_status  in  1  synchronous clear of overrun and lock_lost

## Operation
- Holding: each channel has hold register + pending flag. Valid pulse loads hold and sets pending. If pending already set and not being drained that cycle: overwrite with new word, set overrun bit. Valid and drain of the same channel on the same edge: hold loads new word, pending stays 1, no overrun.
- Output register: loads when empty or being accepted (cic_valid & cic_ready). Selection among pending channels: only one pending -> that one; both pending -> channel opposite to last issued (last_chan resets to 1, so left wins first). Loading clears that channel's pending. No pending -> cic_valid drops after acceptance.
- cic_valid, cic_data, cic_chan never change while cic_valid & !cic_ready.
- Lock FSM, states SEARCH, RUN. Frame timer counts bclk since last left pulse, saturating at FRAME_TIMEOUT; cleared by left pulse. seen_right flag set by right pulse, cleared by left pulse.
- Good frame: left pulse arriving with seen_right = 1 and timer < FRAME_TIMEOUT. Bad: left pulse with seen_right = 0, or timer reaching FRAME_TIMEOUT.
- SEARCH: good frame increments good count; bad event clears it; count reaching LOCK_FRAMES -> RUN (locked = 1 on next edge).
- RUN: any bad event -> SEARCH, good count cleared, lock_lost set.
- clear_status clears sticky bits; a set event on the same edge wins.

## Timing
- Reset values: cic_valid 0, cic_data 0, cic_chan 0, locked 0, overrun 2'b00, lock_lost 0; holds 0, pendings 0, FSM SEARCH, timer 0, last_chan 1.
- Latency: valid pulse at edge k -> pending at k; output register loaded at k+1 if free -> cic_valid high after edge k+1.
- Throughput: one sample per cycle with cic_ready held high.
- Reset mid-handshake: outputs return to reset values immediately (asynchronous); in-flight sample discarded.
- Lock: with 64-cycle frames, locked rises on the edge of the LOCK_FRAMES-th good left pulse; falls on the edge the timer hits FRAME_TIMEOUT.

## Configuration
- DDC_SCHED_MUTE_EN defined: while in SEARCH, the output register loads 0 in place of hold data (channel tag and handshake unchanged); RUN forwards data.
- Undefined: data forwarded unmodified in both states; lock FSM and status still operate.

## Test plan
- Reset then 64-cycle frames L=0x1234 at cycle 0, R=0x5678 at cycle 32, cic_ready=1 -> cic_valid one cycle after each pulse, chan 0 then 1; locked rises on 4th good left pulse; with mute enabled, data 0 before lock and 0x1234/0x5678 after.
- Left and right pulses on the same cycle, ready=1 -> left issued first, right next cycle; following simultaneous pair after a right issue -> left first again (round-robin from last_chan).
- cic_ready=0 for 200 cycles across 3 frames -> cic_valid/cic_data stable; overrun = 2'b11; after ready returns, newest words delivered; clear_status -> overrun 0.
- Locked, then lrclk stops -> locked falls exactly 96 cycles after last left pulse; lock_lost = 1; 4 good frames relock.
- Locked, one right pulse dropped -> next left pulse is bad: SEARCH, lock_lost set, left word still queued.
- Assert rst while cic_valid=1 & ready=0 -> all outputs zero immediately; no stale sample after release.
